// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// Single-port block-RAM data memory sitting between the load/store unit and
// the on-chip RAM. One request is in flight at a time; every accepted request
// yields exactly one rsp_valid pulse.
//
// Parameters:
//   DEPTH   memory size in 32-bit words (power of two, >= 4)
//   RD_LAT  cycles from load acceptance to response (1..4)
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset (control only)
//   req_valid / req_ready      request handshake (accept on valid && ready)
//   req_we                     1 = store, 0 = load
//   req_size                   00 byte, 01 half, 10 word, 11 reserved (error)
//   req_signed                 sign-extend sub-word loads
//   req_addr, req_wdata        byte address, right-aligned store data
//   rsp_valid                  one-cycle response pulse
//   rsp_rdata                  load result, 0 for stores and errors
//   rsp_err                    request rejected (alignment, size or range)
//   busy                       inverse of req_ready
module data_mem_ctrl #(
  parameter int DEPTH  = 1024,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);
  // WAIT lasts RD_LAT-1 cycles; the counter holds the extra cycles still to go.
  localparam logic [2:0] LAT_INIT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_t;

  // Size / alignment check; range is checked separately on the upper bits.
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] lane);
    logic e;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = lane[0];
      2'b10:   e = (lane != 2'b00);
      default: e = 1'b1;
    endcase
    return e;
  endfunction

  // Byte-lane enables for a store of the given size at the given lane.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across lanes; the enables pick the right copy.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      2'b00:   d = {4{wdata[7:0]}};
      2'b01:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Shift the addressed lane down and extend; word loads ignore sgn.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                               input logic [1:0] size, input logic sgn);
    logic [31:0] sh;
    logic [31:0] ext;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   ext = sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
      2'b01:   ext = sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      default: ext = word;
    endcase
    return ext;
  endfunction

  logic [31:0] mem [0:DEPTH-1];

  state_t      state_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic [2:0]  lat_cnt_r;
  logic [31:0] rd_word_r;
  logic [1:0]  lane_r;
  logic [1:0]  size_r;
  logic        signed_r;

  logic          accept_s;
  logic [AW-1:0] idx_s;
  logic          req_err_s;
  logic          wr_en_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_lanes_s;
  logic [31:0]   mem_word_s;
  logic          direct_rsp_s;

  assign accept_s      = req_valid && req_ready_r;
  assign idx_s         = req_addr[AW+1:2];
  // Any set bit above the index field is out of range (no wrap-around).
  assign req_err_s     = align_err(req_size, req_addr[1:0]) || (|req_addr[31:AW+2]);
  // rst_n gating keeps a request seen during reset from touching the array.
  assign wr_en_s       = accept_s && req_we && !req_err_s && rst_n;
  assign be_s          = byte_en(req_size, req_addr[1:0]);
  assign wdata_lanes_s = lane_data(req_size, req_wdata);
  assign mem_word_s    = mem[idx_s];
  // Stores, errors and single-cycle loads respond on the cycle after accept.
  assign direct_rsp_s  = req_we || req_err_s || (RD_LAT == 1);

  assign req_ready = req_ready_r;
  assign busy      = ~req_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_err   = rsp_err_r;
  assign rsp_rdata = rsp_rdata_r;

  // Byte-enable write port; the array has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem[idx_s][i*8 +: 8] <= wdata_lanes_s[i*8 +: 8];
        end
      end
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      lat_cnt_r   <= 3'd0;
      rd_word_r   <= 32'h0000_0000;
      lane_r      <= 2'b00;
      size_r      <= 2'b00;
      signed_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, RESP: begin
          if (accept_s) begin
            if (direct_rsp_s) begin
              state_r     <= RESP;
              req_ready_r <= 1'b1;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= req_err_s;
              rsp_rdata_r <= (req_we || req_err_s) ? 32'h0000_0000
                           : load_extract(mem_word_s, req_addr[1:0], req_size, req_signed);
            end else begin
              // Word is read now; lane selection is applied on the way out.
              state_r     <= WAIT;
              req_ready_r <= 1'b0;
              rsp_valid_r <= 1'b0;
              rsp_err_r   <= 1'b0;
              rsp_rdata_r <= 32'h0000_0000;
              lat_cnt_r   <= LAT_INIT;
              rd_word_r   <= mem_word_s;
              lane_r      <= req_addr[1:0];
              size_r      <= req_size;
              signed_r    <= req_signed;
            end
          end else begin
            state_r     <= IDLE;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
          end
        end
        WAIT: begin
          if (lat_cnt_r == 3'd0) begin
            state_r     <= RESP;
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= load_extract(rd_word_r, lane_r, size_r, signed_r);
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          rsp_valid_r <= 1'b0;
          rsp_err_r   <= 1'b0;
          rsp_rdata_r <= 32'h0000_0000;
          lat_cnt_r   <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed testbench for data_mem_ctrl. Four instances share the request
// fields but have their own req_valid: u0 (RD_LAT 2, DEPTH 1024),
// u1 (RD_LAT 3), u2 (RD_LAT 1), u3 (RD_LAT 4), the last three with DEPTH 16.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  vld;
  logic        we;
  logic [1:0]  size;
  logic        sgn;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  rdy;
  logic [3:0]  rv;
  logic [3:0]  er;
  logic [3:0]  bz;
  logic [31:0] rd [4];

  int checks;
  int failures;

  data_mem_ctrl #(.DEPTH(1024), .RD_LAT(2)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]), .busy(bz[0]));
  data_mem_ctrl #(.DEPTH(16), .RD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]), .busy(bz[1]));
  data_mem_ctrl #(.DEPTH(16), .RD_LAT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]), .busy(bz[2]));
  data_mem_ctrl #(.DEPTH(16), .RD_LAT(4)) u3 (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[3]), .req_ready(rdy[3]), .req_we(we),
    .req_size(size), .req_signed(sgn), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv[3]), .rsp_rdata(rd[3]), .rsp_err(er[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the expected one.
  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request on instance k; returns the response and cycles to rsp_valid
  // (1 = the cycle right after the accept edge) and how many of those had ready low.
  task automatic xact(input int k, input logic w, input logic [1:0] s, input logic sg,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] data, output logic err,
                      output int lat, output int nbusy);
    int guard;
    @(negedge clk);
    we = w; size = s; sgn = sg; addr = a; wdata = d; vld[k] = 1'b1;
    guard = 0;
    while (rdy[k] !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) chk_eq("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    // Scramble the fields: the controller must use its registered copy.
    vld[k] = 1'b0; addr = 32'hFFFF_FFFC; wdata = 32'h5A5A_5A5A; we = ~w; size = 2'b10; sgn = ~sg;
    lat = 0;
    nbusy = 0;
    do begin
      @(negedge clk);
      lat++;
      if (rdy[k] !== 1'b1) nbusy++;
    end while (rv[k] !== 1'b1 && lat < 12);
    if (rv[k] !== 1'b1) chk_eq("rsp_timeout", 32'd0, 32'd1);
    data = rd[k];
    err  = er[k];
  endtask

  task automatic do_store(input string tag, input int k, input logic [1:0] s,
                          input logic [31:0] a, input logic [31:0] d);
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nb;
    xact(k, 1'b1, s, 1'b0, a, d, data, err, lat, nb);
    chk_eq({tag, "_err"}, 32'(err), 32'd0);
    chk_eq({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  task automatic do_load(input string tag, input int k, input logic [1:0] s, input logic sg,
                         input logic [31:0] a, input logic [31:0] exp, input int exp_lat);
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nb;
    xact(k, 1'b0, s, sg, a, 32'h0, data, err, lat, nb);
    chk_eq({tag, "_data"}, data, exp);
    chk_eq({tag, "_err"}, 32'(err), 32'd0);
    chk_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk_eq({tag, "_busy"}, 32'(nb), 32'(exp_lat - 1));
  endtask

  task automatic do_err(input string tag, input int k, input logic w, input logic [1:0] s,
                        input logic [31:0] a, input logic [31:0] d);
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nb;
    xact(k, w, s, 1'b0, a, d, data, err, lat, nb);
    chk_eq({tag, "_err"}, 32'(err), 32'd1);
    chk_eq({tag, "_data"}, data, 32'h0);
    chk_eq({tag, "_lat"}, 32'(lat), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic seen;
    checks = 0;
    failures = 0;
    rst_n = 1'b0; vld = 4'b0000; we = 1'b0; size = 2'b00; sgn = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    chk_eq("rst_ready", 32'(rdy[0]), 32'd1);
    chk_eq("rst_busy", 32'(bz[0]), 32'd0);
    chk_eq("rst_valid", 32'(rv[0]), 32'd0);
    chk_eq("rst_rdata", rd[0], 32'h0);
    chk_eq("rst_err", 32'(er[0]), 32'd0);
    rst_n = 1'b1;

    // Word store then load.
    do_store("st_w10", 0, 2'b10, 32'h10, 32'hDEAD_BEEF);
    do_load("ld_w10", 0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2);

    // Sub-word access.
    do_store("st_w20", 0, 2'b10, 32'h20, 32'h1122_3344);
    do_store("st_b22", 0, 2'b00, 32'h22, 32'h1234_56AA);
    do_load("ld_w20", 0, 2'b10, 1'b0, 32'h20, 32'h11AA_3344, 2);
    do_load("ld_sb22", 0, 2'b00, 1'b1, 32'h22, 32'hFFFF_FFAA, 2);
    do_load("ld_uh22", 0, 2'b01, 1'b0, 32'h22, 32'h0000_11AA, 2);
    do_load("ld_sh20", 0, 2'b01, 1'b1, 32'h20, 32'h0000_3344, 2);
    do_store("st_w24", 0, 2'b10, 32'h24, 32'h0000_0000);
    do_store("st_h26", 0, 2'b01, 32'h26, 32'hFFFF_C0DE);
    do_load("ld_w24s", 0, 2'b10, 1'b1, 32'h24, 32'hC0DE_0000, 2);
    do_load("ld_sh26", 0, 2'b01, 1'b1, 32'h26, 32'hFFFF_C0DE, 2);
    do_load("ld_ub27", 0, 2'b00, 1'b0, 32'h27, 32'h0000_00C0, 2);
    do_load("ld_sb25", 0, 2'b00, 1'b1, 32'h25, 32'h0000_0000, 2);

    // Errors: misalignment, reserved size, out of range; targets unchanged.
    do_err("err_ldw21", 0, 1'b0, 2'b10, 32'h21, 32'h0);
    do_err("err_sth23", 0, 1'b1, 2'b01, 32'h23, 32'h0000_FFFF);
    do_err("err_sz11", 0, 1'b1, 2'b11, 32'h20, 32'hFFFF_FFFF);
    do_err("err_range", 0, 1'b0, 2'b10, 32'h1000, 32'h0);
    do_err("err_hiaddr", 0, 1'b1, 2'b10, 32'h8000_0010, 32'h0BAD_0BAD);
    do_load("ld_w20_post", 0, 2'b10, 1'b0, 32'h20, 32'h11AA_3344, 2);
    do_load("ld_w10_post", 0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2);

    // Back-to-back stores, one accepted on every edge.
    @(negedge clk);
    we = 1'b1; size = 2'b10; sgn = 1'b0; addr = 32'h100; wdata = 32'hA000_0000; vld[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk_eq("b2b_rsp", 32'(rv[0]), 32'd1);
      chk_eq("b2b_ready", 32'(rdy[0]), 32'd1);
      if (i < 7) begin
        addr = 32'h100 + 32'(4 * (i + 1));
        wdata = 32'hA000_0000 + 32'(i + 1);
      end else begin
        vld[0] = 1'b0;
      end
    end
    @(negedge clk);
    chk_eq("b2b_end", 32'(rv[0]), 32'd0);
    do_load("ld_b2b0", 0, 2'b10, 1'b0, 32'h100, 32'hA000_0000, 2);
    do_load("ld_b2b4", 0, 2'b10, 1'b0, 32'h110, 32'hA000_0004, 2);
    do_load("ld_b2b7", 0, 2'b10, 1'b0, 32'h11C, 32'hA000_0007, 2);

    // RD_LAT = 3.
    do_store("u1_st0", 1, 2'b10, 32'h0, 32'h55AA_1234);
    do_store("u1_st4", 1, 2'b10, 32'h4, 32'h8765_4321);
    do_load("u1_ld0", 1, 2'b10, 1'b0, 32'h0, 32'h55AA_1234, 3);
    do_load("u1_ld4", 1, 2'b10, 1'b0, 32'h4, 32'h8765_4321, 3);
    do_load("u1_sb7", 1, 2'b00, 1'b1, 32'h7, 32'hFFFF_FF87, 3);
    do_load("u1_uh2", 1, 2'b01, 1'b0, 32'h2, 32'h0000_55AA, 3);

    // RD_LAT = 1 and 4.
    do_store("u2_st8", 2, 2'b10, 32'h8, 32'hCAFE_F00D);
    do_load("u2_ld8", 2, 2'b10, 1'b0, 32'h8, 32'hCAFE_F00D, 1);
    do_load("u2_shA", 2, 2'b01, 1'b1, 32'hA, 32'hFFFF_CAFE, 1);
    do_store("u3_st8", 3, 2'b10, 32'h8, 32'hCAFE_F00D);
    do_load("u3_ld8", 3, 2'b10, 1'b0, 32'h8, 32'hCAFE_F00D, 4);
    do_err("u3_range", 3, 1'b0, 2'b10, 32'h40, 32'h0);

    // Reset during WAIT drops the pending load.
    @(negedge clk);
    we = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h10; vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    @(negedge clk);
    chk_eq("mid_wait_ready", 32'(rdy[0]), 32'd0);
    chk_eq("mid_wait_busy", 32'(bz[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_ready", 32'(rdy[0]), 32'd1);
    chk_eq("arst_busy", 32'(bz[0]), 32'd0);
    chk_eq("arst_valid", 32'(rv[0]), 32'd0);
    chk_eq("arst_rdata", rd[0], 32'h0);
    chk_eq("arst_err", 32'(er[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rv[0] === 1'b1) seen = 1'b1;
    end
    chk_eq("arst_no_rsp", 32'(seen), 32'd0);
    do_load("arst_keep0", 0, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 2);
    do_load("arst_keep1", 1, 2'b10, 1'b0, 32'h4, 32'h8765_4321, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
